conversor_bases_seq: RTL and testbench

Sequential, parametrised base converter. It turns an unsigned `LARGURA`-bit value into decimal, hexadecimal, octal or binary digits and drives `NUM_DIG` active-low 7-segment displays. Each conversion is one start/done transaction:
- Decimal uses a bit-serial divide-by-10, one quotient bit per cycle.
- Power-of-two bases emit one digit per cycle.
- Leading zeros are blanked, and an overflow flag is raised when the value needs more digits than there are displays.

It sits between the ULA result register and the board displays.

---
 rtl/conversor_pkg.sv | 32 +++
 rtl/decodificador_7seg.sv | 32 +++
 rtl/divisor_serial_10.sv | 37 +++
 rtl/conversor_bases_seq.sv | 158 +++++++++++++++
 tb/tb_conversor_bases_seq.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/conversor_pkg.sv
// Shared types and constants for the sequential base converter:
// base codes, FSM states, blank glyph and digit width per base.
package conversor_pkg;

  typedef enum logic [1:0] {
    BASE_DEC = 2'b00,
    BASE_HEX = 2'b01,
    BASE_OCT = 2'b10,
    BASE_BIN = 2'b11
  } base_t;

  typedef enum logic [2:0] {
    OCIOSO,
    DIVIDE,
    GRAVA,
    DIGITO,
    FIM
  } estado_t;

  localparam logic [6:0] SEG_APAGADO = 7'b1111111;

  // Decimal is not a power of two, so it has no shift width and reports 0.
  function automatic int unsigned bits_por_digito(base_t base);
    case (base)
      BASE_HEX: return 4;
      BASE_OCT: return 3;
      BASE_BIN: return 1;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/decodificador_7seg.sv
// Hex digit to active-low 7-segment glyph, segment a in bit 0 through g in bit 6.
module decodificador_7seg
  import conversor_pkg::*;
(
  input  logic [3:0] digito,
  output logic [6:0] segmentos
);

  always_comb begin
    segmentos = SEG_APAGADO;
    case (digito)
      4'h0: segmentos = 7'b1000000;
      4'h1: segmentos = 7'b1111001;
      4'h2: segmentos = 7'b0100100;
      4'h3: segmentos = 7'b0110000;
      4'h4: segmentos = 7'b0011001;
      4'h5: segmentos = 7'b0010010;
      4'h6: segmentos = 7'b0000010;
      4'h7: segmentos = 7'b1111000;
      4'h8: segmentos = 7'b0000000;
      4'h9: segmentos = 7'b0010000;
      4'hA: segmentos = 7'b0001000;
      4'hB: segmentos = 7'b0000011;
      4'hC: segmentos = 7'b1000110;
      4'hD: segmentos = 7'b0100001;
      4'hE: segmentos = 7'b0000110;
      4'hF: segmentos = 7'b0001110;
      default: segmentos = SEG_APAGADO;
    endcase
  end

endmodule

// File: rtl/divisor_serial_10.sv
// Restoring divide-by-10, one quotient bit per passo; the dividend register
// shifts left and collects the quotient bits in its place.
module divisor_serial_10 #(
  parameter int LARGURA = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               carrega,
  input  logic               passo,
  input  logic [LARGURA-1:0] dividendo,
  output logic [LARGURA-1:0] quociente,
  output logic [3:0]         resto
);

  logic [4:0] parcial;
  logic [4:0] subtraido;
  logic       cabe;

  // The remainder stays below 10, so the partial value never exceeds 19.
  assign parcial   = {resto, quociente[LARGURA-1]};
  assign cabe      = (parcial >= 5'd10);
  assign subtraido = parcial - 5'd10;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quociente <= '0;
      resto     <= '0;
    end else if (carrega) begin
      quociente <= dividendo;
      resto     <= '0;
    end else if (passo) begin
      quociente <= {quociente[LARGURA-2:0], cabe};
      resto     <= cabe ? subtraido[3:0] : parcial[3:0];
    end
  end

endmodule

// File: rtl/conversor_bases_seq.sv
// Sequential base converter: peels digits off the captured value one at a time
// and commits digits, glyphs and the overflow flag in a single FIM cycle.
module conversor_bases_seq
  import conversor_pkg::*;
#(
  parameter int LARGURA = 16,
  parameter int NUM_DIG = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iniciar,
  input  logic [LARGURA-1:0]   valor_binario,
  input  logic [1:0]           base_selecionada,
  output logic                 ocupado,
  output logic                 pronto,
  output logic                 estouro,
  output logic [4*NUM_DIG-1:0] digitos,
  output logic [7*NUM_DIG-1:0] HEX
);

  localparam int IDX_W = $clog2(NUM_DIG + 1);
  localparam int CNT_W = $clog2(LARGURA + 1);

  estado_t              estado, prox_estado;
  base_t                base;
  logic [LARGURA-1:0]   dividendo, dividendo_desloc, quociente, entrada_div;
  logic [3:0]           resto, digito_novo;
  logic [IDX_W-1:0]     idx;
  logic [CNT_W-1:0]     cnt;
  logic [4*NUM_DIG-1:0] buf_trab;
  logic [7*NUM_DIG-1:0] hex_prox;
  logic                 ultimo, sai_grava, sai_digito;
  logic                 carrega_div, passo_div, armazena;

  assign ultimo           = (idx == IDX_W'(NUM_DIG - 1));
  assign dividendo_desloc = dividendo >> bits_por_digito(base);
  assign sai_grava        = (quociente == '0) || ultimo;
  assign sai_digito       = (dividendo_desloc == '0) || ultimo;
  assign entrada_div      = (estado == OCIOSO) ? valor_binario : quociente;

  always_comb begin
    digito_novo = 4'd0;
    if (estado == GRAVA) begin
      digito_novo = resto;
    end else begin
      case (base)
        BASE_HEX: digito_novo = dividendo[3:0];
        BASE_OCT: digito_novo = {1'b0, dividendo[2:0]};
        BASE_BIN: digito_novo = {3'b000, dividendo[0]};
        default:  digito_novo = 4'd0;
      endcase
    end
  end

  divisor_serial_10 #(.LARGURA(LARGURA)) u_divisor (
    .clk       (clk),
    .rst       (rst),
    .carrega   (carrega_div),
    .passo     (passo_div),
    .dividendo (entrada_div),
    .quociente (quociente),
    .resto     (resto)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= OCIOSO;
    else     estado <= prox_estado;
  end

  always_comb begin
    prox_estado = estado;
    case (estado)
      OCIOSO: if (iniciar)
                prox_estado = (base_t'(base_selecionada) == BASE_DEC) ? DIVIDE : DIGITO;
      DIVIDE: if (cnt == CNT_W'(LARGURA - 1)) prox_estado = GRAVA;
      GRAVA:  prox_estado = sai_grava ? FIM : DIVIDE;
      DIGITO: if (sai_digito) prox_estado = FIM;
      FIM:    prox_estado = OCIOSO;
      default: prox_estado = OCIOSO;
    endcase
  end

  always_comb begin
    carrega_div = 1'b0;
    passo_div   = 1'b0;
    armazena    = 1'b0;
    ocupado     = (estado != OCIOSO);
    case (estado)
      OCIOSO: carrega_div = iniciar;
      DIVIDE: passo_div   = 1'b1;
      GRAVA: begin
        armazena    = 1'b1;
        carrega_div = !sai_grava;
      end
      DIGITO: armazena = 1'b1;
      default: ;
    endcase
  end

  // Only the FIM cycle touches the visible outputs, so they hold the
  // previous result throughout a conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base      <= BASE_DEC;
      dividendo <= '0;
      idx       <= '0;
      cnt       <= '0;
      buf_trab  <= '0;
      pronto    <= 1'b0;
      estouro   <= 1'b0;
      digitos   <= '0;
      HEX       <= {NUM_DIG{SEG_APAGADO}};
    end else begin
      pronto <= (estado == FIM);
      case (estado)
        OCIOSO: if (iniciar) begin
          dividendo <= valor_binario;
          base      <= base_t'(base_selecionada);
          idx       <= '0;
          cnt       <= '0;
          buf_trab  <= '0;
        end
        DIVIDE: cnt <= cnt + 1'b1;
        GRAVA: begin
          dividendo <= quociente;
          idx       <= idx + 1'b1;
          cnt       <= '0;
        end
        DIGITO: begin
          dividendo <= dividendo_desloc;
          idx       <= idx + 1'b1;
        end
        FIM: begin
          digitos <= buf_trab;
          HEX     <= hex_prox;
          estouro <= (dividendo != '0);
        end
        default: ;
      endcase
      if (armazena) begin
        for (int p = 0; p < NUM_DIG; p++) begin
          if (idx == IDX_W'(p)) buf_trab[4*p +: 4] <= digito_novo;
        end
      end
    end
  end

  // Positions at or beyond the stored digit count are leading zeros: blank them.
  for (genvar p = 0; p < NUM_DIG; p++) begin : g_display
    logic [6:0] seg;
    decodificador_7seg u_dec (
      .digito    (buf_trab[4*p +: 4]),
      .segmentos (seg)
    );
    assign hex_prox[7*p +: 7] = (IDX_W'(p) < idx) ? seg : SEG_APAGADO;
  end

endmodule

// File: tb/tb_conversor_bases_seq.sv
// Scoreboard bench for conversor_bases_seq: a reference model computes digits,
// glyphs, overflow and latency at each accepted start; results are popped on pronto.
module tb_conversor_bases_seq;

  localparam int LW = 16;
  localparam int ND = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            iniciar;
  logic [LW-1:0]   valor_binario;
  logic [1:0]      base_selecionada;
  logic            ocupado, pronto, estouro;
  logic [4*ND-1:0] digitos;
  logic [7*ND-1:0] HEX;

  typedef struct {
    logic [4*ND-1:0] dig;
    logic [7*ND-1:0] hex;
    logic            est;
    int              lat;
    int              aceite;
  } exp_t;

  exp_t            sb[$];
  int              checks = 0;
  int              erros  = 0;
  int              ciclo  = 0;
  bit              clk_en = 1'b0;
  logic [4*ND-1:0] ult_dig = '0;
  logic [7*ND-1:0] ult_hex = {ND{7'h7F}};

  conversor_bases_seq #(.LARGURA(LW), .NUM_DIG(ND)) dut (
    .clk              (clk),
    .rst              (rst),
    .iniciar          (iniciar),
    .valor_binario    (valor_binario),
    .base_selecionada (base_selecionada),
    .ocupado          (ocupado),
    .pronto           (pronto),
    .estouro          (estouro),
    .digitos          (digitos),
    .HEX              (HEX)
  );

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  always @(posedge clk) ciclo++;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    checks++;
    if (obs !== esp) begin
      erros++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  function automatic logic [6:0] glifo(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic exp_t modelo(input int unsigned v, input logic [1:0] b);
    exp_t        e;
    int unsigned radix;
    int          n;
    int          d;
    radix = (b == 2'b00) ? 10 : (b == 2'b01) ? 16 : (b == 2'b10) ? 8 : 2;
    e.dig = '0;
    e.hex = {ND{7'h7F}};
    n = 0;
    do begin
      d = int'(v % radix);
      e.dig[4*n +: 4] = d[3:0];
      e.hex[7*n +: 7] = glifo(d);
      v = v / radix;
      n++;
    end while (v != 0 && n < ND);
    e.est    = (v != 0);
    e.lat    = (b == 2'b00) ? n * (LW + 1) + 1 : n + 1;
    e.aceite = 0;
    return e;
  endfunction

  task automatic startConversion(input int unsigned v, input logic [1:0] b);
    exp_t e;
    @(negedge clk);
    iniciar          = 1'b1;
    valor_binario    = v[LW-1:0];
    base_selecionada = b;
    @(posedge clk);
    #1;
    iniciar       = 1'b0;
    valor_binario = ~valor_binario;
    e = modelo(v, b);
    e.aceite = ciclo;
    sb.push_back(e);
    checkOutput("ocupado_sobe", ocupado, 1);
  endtask

  task automatic waitResult();
    exp_t e;
    bit   achou = 1'b0;
    for (int n = 0; n < 400 && !achou; n++) begin
      @(posedge clk);
      #1;
      if (pronto) achou = 1'b1;
    end
    if (!achou) checkOutput("timeout_pronto", 0, 1);
    if (sb.size() == 0) begin
      checkOutput("scoreboard_vazio", 0, 1);
    end else begin
      e = sb.pop_front();
      checkOutput("digitos",  digitos, e.dig);
      checkOutput("hex",      HEX, e.hex);
      checkOutput("estouro",  estouro, e.est);
      checkOutput("latencia", ciclo - e.aceite, e.lat);
      checkOutput("ocupado_fim", ocupado, 0);
      ult_dig = e.dig;
      ult_hex = e.hex;
      @(posedge clk);
      #1;
      checkOutput("pronto_pulso", pronto, 0);
    end
  endtask

  task automatic applyStimulus(input int unsigned v, input logic [1:0] b);
    startConversion(v, b);
    waitResult();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_hex"},     HEX, {ND{7'h7F}});
    checkOutput({tag, "_ocupado"}, ocupado, 0);
    checkOutput({tag, "_pronto"},  pronto, 0);
    checkOutput({tag, "_estouro"}, estouro, 0);
    checkOutput({tag, "_digitos"}, digitos, 0);
  endtask

  initial begin
    rst = 1'b1;
    iniciar = 1'b0;
    valor_binario = '0;
    base_selecionada = 2'b00;
    #2;
    checkResetValues("reset");
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(12345, 2'b00);
    applyStimulus(16'hBEEF, 2'b01);
    applyStimulus(0, 2'b00);
    applyStimulus(16'h00FF, 2'b11);
    applyStimulus(16'o777, 2'b10);
    applyStimulus(0, 2'b01);

    $display("[TB] start ignored while busy");
    startConversion(500, 2'b00);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("hold_digitos", digitos, ult_dig);
    checkOutput("hold_hex", HEX, ult_hex);
    @(negedge clk);
    iniciar = 1'b1;
    valor_binario = 16'd99;
    base_selecionada = 2'b01;
    @(negedge clk);
    iniciar = 1'b0;
    waitResult();

    $display("[TB] reset during conversion");
    startConversion(1234, 2'b00);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    sb.delete();
    checkResetValues("abort");
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(42, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, erros);
    $finish;
  end

endmodule
